// File: rtl/reset_sync_sequencer_if.sv
// reset_sync_sequencer_if: request/response bundle for reset_sync_sequencer.
// master = the side that raises reset requests and consumes the synchronized
// resets, slave = the sequencer itself. The status signals exist only when
// RESET_SYNC_SEQUENCER_STATUS_EN is defined.
interface reset_sync_sequencer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] io_d;
  logic [WIDTH-1:0] io_q;
`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
  logic [WIDTH-1:0] io_glitch;
  logic             io_glitch_clr;
  logic             io_released;

  modport master (output io_d, output io_glitch_clr,
                  input  io_q, input  io_glitch, input io_released);
  modport slave  (input  io_d, input  io_glitch_clr,
                  output io_q, output io_glitch, output io_released);
`else
  modport master (output io_d, input  io_q);
  modport slave  (input  io_d, output io_q);
`endif
endinterface

// File: rtl/reset_sync_sequencer.sv
// reset_sync_sequencer: WIDTH independent reset requests, each synchronized
// through a DEPTH-stage chain, released only after HOLD consecutive low
// cycles, optionally in strict index order (SEQUENCED=1: channel i counts
// only while channel i-1 is released, and follows it back into reset).
// Optional status (sticky glitch flags, all-released flag) is built when
// RESET_SYNC_SEQUENCER_STATUS_EN is defined; io_q behaviour is unchanged.
module reset_sync_sequencer #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 3,
  parameter int HOLD      = 4,
  parameter int SEQUENCED = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  reset_sync_sequencer_if.slave io
);

  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    ST_ASSERTED = 2'd0,
    ST_COUNTING = 2'd1,
    ST_RELEASED = 2'd2
  } state_t;

  // Registered reset outputs of all channels, gathered so that channel i can
  // see channel i-1.
  logic [WIDTH-1:0] io_q_vec;

`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
  logic [WIDTH-1:0] glitch_set_vec;
  logic [WIDTH-1:0] glitch_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [DEPTH-1:0] sync_q;
      logic             s;
      logic             prev_q;
      logic             cascade;
      state_t           state_q, state_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             out_q, out_d;

      // Lower neighbour's output; channel 0 has none and is never held back.
      if (gi == 0) begin : g_first
        assign prev_q = 1'b0;
      end else begin : g_next
        assign prev_q = io_q_vec[gi-1];
      end

      assign s       = sync_q[DEPTH-1];
      assign cascade = (SEQUENCED != 0) && prev_q;

      // Synchronizer chain, FSM state, hold counter and output flop.
      always_ff @(posedge clock) begin
        if (reset) begin
          sync_q  <= '1;
          state_q <= ST_ASSERTED;
          cnt_q   <= '0;
          out_q   <= 1'b1;
        end else begin
          sync_q  <= {sync_q[DEPTH-2:0], io.io_d[gi]};
          state_q <= state_d;
          cnt_q   <= cnt_d;
          out_q   <= out_d;
        end
      end

      // Next state: request > neighbour cascade > hold counting.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (s) begin
          state_d = ST_ASSERTED;
          cnt_d   = '0;
        end else if (cascade) begin
          // Lower channel is (back) in reset: follow it and restart the window.
          state_d = ST_ASSERTED;
          cnt_d   = '0;
        end else begin
          // Reaching here means the count enable is true.
          case (state_q)
            ST_ASSERTED, ST_COUNTING: begin
              // The edge that completes the HOLD-th low cycle also releases.
              if (cnt_q + CW'(1) == CW'(HOLD)) begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
              end else begin
                state_d = ST_COUNTING;
                cnt_d   = cnt_q + CW'(1);
              end
            end
            ST_RELEASED: begin
              state_d = ST_RELEASED;
            end
            default: begin
              state_d = ST_ASSERTED;
              cnt_d   = '0;
            end
          endcase
        end
        out_d = (state_d != ST_RELEASED);
      end

      assign io_q_vec[gi] = out_q;

`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
      // A request seen while counting aborts the window: that is a glitch.
      assign glitch_set_vec[gi] = s && (state_q == ST_COUNTING);
`endif
    end
  endgenerate

  assign io.io_q = io_q_vec;

`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
  // Sticky glitch flags; a new glitch beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= (io.io_glitch_clr ? '0 : glitch_q) | glitch_set_vec;
    end
  end

  assign io.io_glitch   = glitch_q;
  assign io.io_released = &(~io_q_vec);
`endif

endmodule

// File: tb/tb_reset_sync_sequencer.sv
// tb_reset_sync_sequencer: two sequencer instances driven from the same
// request stream -- A (WIDTH=2, DEPTH=3, HOLD=4, sequenced) and
// B (WIDTH=3, DEPTH=2, HOLD=3, independent). Directed scenarios with fixed
// expectations, then random requests compared against a behavioural model.
// Status checks are included when RESET_SYNC_SEQUENCER_STATUS_EN is defined.
module tb_reset_sync_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  reset_sync_sequencer_if #(.WIDTH(2)) ifa ();
  reset_sync_sequencer_if #(.WIDTH(3)) ifb ();

  reset_sync_sequencer #(.WIDTH(2), .DEPTH(3), .HOLD(4), .SEQUENCED(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .io    (ifa)
  );

  reset_sync_sequencer #(.WIDTH(3), .DEPTH(2), .HOLD(3), .SEQUENCED(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .io    (ifb)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;

  // Behavioural model: per instance, the last DEPTH raw samples (oldest
  // first), and per channel the output level, the run of counted low cycles
  // and the sticky glitch flag.
  logic [3:0] hist [2][8];
  bit         mq   [2][4];
  int         mc   [2][4];
  bit         mg   [2][4];

  function automatic int p_w(input int k);    return (k == 0) ? 2 : 3; endfunction
  function automatic int p_dep(input int k);  return (k == 0) ? 3 : 2; endfunction
  function automatic int p_hold(input int k); return (k == 0) ? 4 : 3; endfunction
  function automatic bit p_seq(input int k);  return (k == 0);         endfunction

  task automatic model_edge(input int k, input logic [3:0] d, input logic rst, input logic clr);
    logic [3:0] s;
    bit         q_old [4];
    bit         gset;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mq[k][i] = 1'b1;
        mc[k][i] = 0;
        mg[k][i] = 1'b0;
      end
      for (int j = 0; j < 8; j++) hist[k][j] = 4'hF;
      return;
    end
    s = hist[k][0];
    for (int i = 0; i < 4; i++) q_old[i] = mq[k][i];
    for (int i = 0; i < p_w(k); i++) begin
      gset = 1'b0;
      if (s[i]) begin
        gset     = q_old[i] && (mc[k][i] > 0);
        mq[k][i] = 1'b1;
        mc[k][i] = 0;
      end else if (p_seq(k) && i > 0 && q_old[i-1]) begin
        mq[k][i] = 1'b1;
        mc[k][i] = 0;
      end else if (q_old[i]) begin
        mc[k][i] = mc[k][i] + 1;
        if (mc[k][i] == p_hold(k)) begin
          mq[k][i] = 1'b0;
          mc[k][i] = 0;
        end
      end
      mg[k][i] = (clr ? 1'b0 : mg[k][i]) | gset;
    end
    for (int j = 0; j < p_dep(k) - 1; j++) hist[k][j] = hist[k][j+1];
    hist[k][p_dep(k)-1] = d;
  endtask

  function automatic logic [3:0] mvec_q(input int k);
    logic [3:0] v = '0;
    for (int i = 0; i < p_w(k); i++) v[i] = mq[k][i];
    return v;
  endfunction

  function automatic logic [3:0] mvec_g(input int k);
    logic [3:0] v = '0;
    for (int i = 0; i < p_w(k); i++) v[i] = mg[k][i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic [3:0] d, input logic rst, input logic clr);
    ifa.io_d = d[1:0];
    ifb.io_d = d[2:0];
    reset    = rst;
`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
    ifa.io_glitch_clr = clr;
    ifb.io_glitch_clr = clr;
`endif
    @(posedge clock);
    model_edge(0, d, rst, clr);
    model_edge(1, d, rst, clr);
    #1;
    n_step++;
    chk("qA", 32'(ifa.io_q), 32'(mvec_q(0)));
    chk("qB", 32'(ifb.io_q), 32'(mvec_q(1)));
`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
    chk("glitchA", 32'(ifa.io_glitch), 32'(mvec_g(0)));
    chk("glitchB", 32'(ifb.io_glitch), 32'(mvec_g(1)));
    chk("releasedA", 32'(ifa.io_released), 32'(~|mvec_q(0)));
    chk("releasedB", 32'(ifb.io_released), 32'(~|mvec_q(1)));
`endif
    $display("step %0d rst=%b d=%b clr=%b qA=%b qB=%b", n_step, rst, d[2:0], clr, ifa.io_q, ifb.io_q);
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("rstA", 32'(ifa.io_q), 32'h3);
      chk("rstB", 32'(ifb.io_q), 32'h7);
    end
  endtask

  // io_d low from edge 1 on a fully asserted block:
  // A bit0 falls after edge 7, bit1 after edge 11; B all bits after edge 5.
  task automatic release_seq(input string tag);
    logic [1:0] ea;
    logic [2:0] eb;
    for (int e = 1; e <= 14; e++) begin
      step(4'b0000, 1'b0, 1'b0);
      ea = (e < 7) ? 2'b11 : (e < 11) ? 2'b10 : 2'b00;
      eb = (e < 5) ? 3'b111 : 3'b000;
      chk({tag, "A"}, 32'(ifa.io_q), 32'(ea));
      chk({tag, "B"}, 32'(ifb.io_q), 32'(eb));
    end
  endtask

  initial begin
    logic [1:0] ea;
    logic [3:0] rd;
    ifa.io_d = '0;
    ifb.io_d = '0;
`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
    ifa.io_glitch_clr = 1'b0;
    ifb.io_glitch_clr = 1'b0;
`endif

    // Reset with requests high, then release from scratch.
    do_reset(5);
    release_seq("rel");

    // Cascade: one-cycle request on channel 0 sampled at edge 1.
    for (int e = 1; e <= 14; e++) begin
      step((e == 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      ea = (e < 4) ? 2'b00 : (e == 4) ? 2'b01 : (e < 8) ? 2'b11 : (e < 12) ? 2'b10 : 2'b00;
      chk("cascA", 32'(ifa.io_q), 32'(ea));
    end

    // Block reset while channel 1 of A is counting, then a full restart.
    do_reset(2);
    for (int e = 1; e <= 8; e++) step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("midrstA", 32'(ifa.io_q), 32'h3);
    chk("midrstB", 32'(ifb.io_q), 32'h7);
    release_seq("restart");

    // Glitch while counting: pulse on channel 0 sampled at edge 4 restarts
    // its window (release after edge 11 instead of 7). Clear pulses at the
    // glitch edge (set wins) and two edges later (clears).
    do_reset(2);
    for (int e = 1; e <= 16; e++) begin
      step((e == 4) ? 4'b0001 : 4'b0000, 1'b0, (e == 7) || (e == 9));
      ea = (e < 11) ? 2'b11 : (e < 15) ? 2'b10 : 2'b00;
      chk("glitchrunA", 32'(ifa.io_q), 32'(ea));
`ifdef RESET_SYNC_SEQUENCER_STATUS_EN
      chk("glitchflagA", 32'(ifa.io_glitch[0]), 32'((e == 7) || (e == 8)));
`endif
    end

    // Random requests, occasional block reset and clear pulses.
    do_reset(1);
    for (int n = 0; n < 300; n++) begin
      rd = '0;
      for (int i = 0; i < 3; i++) rd[i] = ($urandom_range(0, 19) == 0);
      step(rd, ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
